// File: rtl/serial_eq_checker_pkg.sv
// Shared constants and state encoding for the bit-serial equality checker.
package serial_eq_checker_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2'b11 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_eq_checker_xnor_gate.sv
// Two-input XNOR cell: out is 1 when a and b agree.
module xnor_gate (
  input  logic a,
  input  logic b,
  output logic out
);

  assign out = ~(a ^ b);

endmodule

// File: rtl/serial_eq_checker.sv
// Compares two LSB-first serial words over a framed transfer and reports
// equality plus the index of the first differing bit.
module serial_eq_checker
  import serial_eq_checker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          bit_valid,
  input  logic          a_bit,
  input  logic          b_bit,
  output logic          busy,
  output logic          done,
  output logic          equal,
  output logic [CW-1:0] mismatch_idx
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          eq_acc;
  logic          found;
  logic          m;

  xnor_gate u_xnor (
    .a   (a_bit),
    .b   (b_bit),
    .out (m)
  );

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      eq_acc       <= 1'b1;
      found        <= 1'b0;
      equal        <= 1'b0;
      mismatch_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            cnt          <= '0;
            eq_acc       <= 1'b1;
            found        <= 1'b0;
            equal        <= 1'b0;
            mismatch_idx <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (bit_valid) begin
            eq_acc <= eq_acc & m;
            if (!m && !found) begin
              mismatch_idx <= cnt;
              found        <= 1'b1;
            end
            // cnt stops at the last index instead of wrapping.
            if (cnt == LAST_IDX) begin
              state <= DONE;
              equal <= eq_acc & m;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_eq_checker.sv
// Randomized self-checking bench for serial_eq_checker against a word-level model.
module tb_serial_eq_checker;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH);

  logic          clk = 1'b0;
  logic          reset, start, abort, bit_valid, a_bit, b_bit;
  logic          busy, done, equal;
  logic [CW-1:0] mismatch_idx;

  int checks   = 0;
  int failures = 0;

  serial_eq_checker #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .bit_valid    (bit_valid),
    .a_bit        (a_bit),
    .b_bit        (b_bit),
    .busy         (busy),
    .done         (done),
    .equal        (equal),
    .mismatch_idx (mismatch_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_idx(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    d = a ^ b;
    for (int i = 0; i < WIDTH; i++)
      if (d[i]) return i;
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: valid every cycle, 1: valid on odd cycles only, 2: random gaps
  task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int mode, input bit spam_start, output int done_cyc);
    int  c;
    int  k;
    bit  v;
    bit  ok_done;
    done_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("equal_cleared_on_start", equal, 0);
    c = 1;
    k = 0;
    ok_done = 1'b1;
    while (k < WIDTH && c < 300) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : ($urandom_range(0, 2) != 0);
      bit_valid = v;
      a_bit     = a[k];
      b_bit     = b[k];
      start     = spam_start && ($urandom_range(0, 1) == 1);
      tick();
      if (v) k++;
      c++;
      if (k < WIDTH && (done !== 1'b0 || busy !== 1'b1)) ok_done = 1'b0;
    end
    bit_valid = 1'b0;
    start     = 1'b0;
    check("run_no_early_done", ok_done, 1);
    check("all_bits_accepted", k, WIDTH);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 1);
    check("equal_result", equal, (a == b));
    check("mismatch_idx_result", mismatch_idx, ref_idx(a, b));
    done_cyc = c;
    start = spam_start;  // start during DONE must be ignored
    tick();
    start = 1'b0;
    check("done_single_cycle", done, 0);
    check("busy_after_done", busy, 0);
    tick();
    check("idle_stays_idle", busy, 0);
    check("equal_held", equal, (a == b));
    check("idx_held", mismatch_idx, ref_idx(a, b));
  endtask

  initial begin
    int dc;
    logic [WIDTH-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_equal", equal, 0);
    check("reset_idx", mismatch_idx, 0);

    run_cmp(8'hA5, 8'hA5, 0, 1'b0, dc);
    check("done_cycle_continuous", dc, 9);
    run_cmp(8'hA5, 8'hA4, 0, 1'b0, dc);
    run_cmp(8'h35, 8'hB5, 0, 1'b0, dc);
    check("idx_bit7", mismatch_idx, 7);
    run_cmp(8'hFF, 8'h00, 1, 1'b0, dc);
    check("done_cycle_toggle", dc, 16);

    // Abort on the edge of the final bit: no done, back in IDLE.
    start = 1'b1; tick(); start = 1'b0;
    bit_valid = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      a_bit = 1'b1; b_bit = 1'b1;
      abort = (i == WIDTH - 1);
      start = (i == WIDTH - 1);
      tick();
      if (i == WIDTH - 1) begin
        check("abort_no_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_equal", equal, 0);
        check("abort_idx", mismatch_idx, 0);
      end
    end
    abort = 1'b0; bit_valid = 1'b0; start = 1'b0;
    tick();
    check("abort_start_not_taken", busy, 0);
    run_cmp(8'h3C, 8'h3C, 0, 1'b0, dc);

    // abort while idle leaves the held result alone
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle_abort_equal", equal, 1);
    check("idle_abort_busy", busy, 0);

    // Reset after four accepted bits discards the compare.
    start = 1'b1; tick(); start = 1'b0;
    bit_valid = 1'b1; a_bit = 1'b0; b_bit = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bit_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_done", done, 0);
    check("midrun_reset_equal", equal, 0);
    check("midrun_reset_idx", mismatch_idx, 0);
    bit_valid = 1'b1; tick(); bit_valid = 1'b0;
    check("valid_in_idle_ignored", busy, 0);

    run_cmp(8'h5A, 8'h5A, 0, 1'b1, dc);
    check("spam_done_cycle", dc, 9);

    for (int n = 0; n < 25; n++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      run_cmp(ra, rb, int'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1), dc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_eq_checker.md
# serial_eq_checker

Bit-serial equality checker: receives two serial streams of WIDTH bits each, LSB-first, and reports whether the two words are equal. For the first differing bit, it also reports that bit's index. It is the receiving/checking end of the bit-level compare path. Each bit pair is compared by one `xnor_gate`, and the results are accumulated over a framed, handshaked transfer. It sits behind the Basic_gate library as the first sequential consumer of the gate cells.

## Interface
Parameters:
- `WIDTH`, 8, number of bits per compared word; legal range 2..256.
- `CW`, `$clog2(WIDTH)`, width of counter and index; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to begin a compare; honoured only in IDLE.
- `abort`  in  1  cancels an in-progress compare; returns to IDLE with no `done`.
- `bit_valid`  in  1  `a_bit`/`b_bit` carry a bit pair this cycle; honoured only in RUN.
- `a_bit`  in  1  serial stream A, LSB first.
- `b_bit`  in  1  serial stream B, LSB first.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; result valid.
- `equal`  out  1  1 when all WIDTH pairs matched; held until next accepted `start`.
- `mismatch_idx`  out  CW  index of first differing bit; 0 when `equal`=1; held like `equal`.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: accepts bit pairs.
  - DONE: pulses `done` for one cycle, then unconditionally returns to IDLE.
- IDLE→RUN on `start`=1. On that edge:
  - `cnt`←0.
  - `eq_acc`←1.
  - `found`←0.
  - `equal`←0.
  - `mismatch_idx`←0.
- In RUN, each cycle with `bit_valid`=1:
  - `m` = `xnor(a_bit, b_bit)`.
  - `eq_acc`←`eq_acc & m`.
  - If `m`=0 and `found`=0: `mismatch_idx`←`cnt` and `found`←1.
  - `cnt`←`cnt`+1.
- Cycles in RUN with `bit_valid`=0 leave all state unchanged. Gaps are unlimited.
- RUN→DONE on the edge that accepts the bit with `cnt`==WIDTH-1. On that edge, `equal`←final `eq_acc` (including the last bit).
- DONE→IDLE after one cycle. `done`=1 only while in DONE.
- `start` in RUN or DONE is ignored, not queued. `bit_valid` in IDLE or DONE is ignored.
- `abort`=1 in RUN or DONE forces IDLE on the next edge:
  - No `done` pulse.
  - `equal` and `mismatch_idx` keep their values, which were cleared at start.
- `abort` in IDLE has no effect.
- `abort` wins over a simultaneous final `bit_valid` and over `start`.
- `reset` is synchronous and overrides everything. Reset values:
  - State IDLE.
  - `cnt`=0, `eq_acc`=1, `found`=0.
  - `busy`=0, `done`=0, `equal`=0, `mismatch_idx`=0.
- Reset mid-RUN discards the partial compare.
- `cnt` never wraps. Its maximum value is WIDTH-1, and the FSM exits RUN at that point.

## Timing
- `start` sampled at edge 0 → `busy`=1 from cycle 1.
- With `bit_valid` held high from cycle 1, bits are accepted at edges 1..WIDTH. `done`=1 in cycle WIDTH+1, and `busy`=0 from cycle WIDTH+2.
- Minimum start-to-start period is WIDTH+2 cycles. A new `start` is accepted in the first IDLE cycle after DONE.
- `equal` and `mismatch_idx` become valid in the same cycle `done` rises. They are registered outputs, with no combinational path from inputs.
- `busy` and `done` decode directly from the state register.

## Structure
- Shared package/include holds:
  - State encodings: `IDLE`=2'b00, `RUN`=2'b01, `DONE`=2'b10. 2'b11 is illegal and recovers to IDLE.
  - The default `WIDTH` constant.
- One sub-module instance: `xnor_gate` (ports `a`, `b`, `out`) computing `m` from `a_bit`/`b_bit`. No other submodules.
- Counter, accumulator and FSM are local registers in this module.

## Test plan
- WIDTH=8, start, then stream A=B=8'hA5 continuously → `done` in cycle 9, `equal`=1, `mismatch_idx`=0.
- A=8'hA5, B=8'hA4 (bit 0 differs) → `equal`=0, `mismatch_idx`=0. A=8'h35, B=8'hB5 (bit 7 differs) → `equal`=0, `mismatch_idx`=7.
- A=8'hFF, B=8'h00 with `bit_valid` toggled 1/0 every cycle → first mismatch recorded, `mismatch_idx`=0, `done` in cycle 16.
- `abort` asserted on the same edge as the 8th valid bit → no `done` pulse, state IDLE; a subsequent `start` and A=B=8'h3C → `equal`=1.
- `reset` pulsed after 4 bits accepted → all outputs 0 next cycle. Extra `start` pulses during RUN are ignored, with exactly one `done` per accepted `start`.
